instr_seq_player: RTL and testbench
===================================

INSTR_SEQ_PLAYER -- requirements
Module: instr_seq_player

Interface
REQ-001 Parameter XLEN, 64, datapath and result width.
REQ-002 Parameter ILEN, 64, instruction word width driven to the SoC instr_in port.
REQ-003 Parameter DEPTH, 32, program entries (power of two, 2..256); AW = clog2(DEPTH).
REQ-004 Parameter RES_LAT, 1, cycles from instruction issue to a valid dut_result (1..8).
REQ-005 Parameter NOP_WORD, ILEN'h13, word driven whenever no instruction is issued.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 load_en  input  1  write one program entry this cycle.
REQ-009 load_addr  input  AW  entry index.
REQ-010 load_instr  input  ILEN  instruction word.
REQ-011 load_expect  input  XLEN  expected result.
REQ-012 load_chk  input  1  entry is checked against dut_result.
REQ-013 start  input  1  one-cycle pulse, begins playback at entry 0.
REQ-014 stop  input  1  one-cycle pulse, ends playback after outstanding checks.
REQ-015 loop_mode  input  1  wrap to entry 0 after the last entry.
REQ-016 gap  input  4  NOP cycles inserted after every issued entry.
REQ-017 count  input  AW+1  entries to play, sampled at start.
REQ-018 dut_result  input  XLEN  result returned by the SoC.
REQ-019 instr_out  output  ILEN  instruction word to the SoC.
REQ-020 instr_valid  output  1  instr_out holds a program entry.
REQ-021 busy  output  1  playback or drain in progress.
REQ-022 done  output  1  one-cycle pulse on completion.
REQ-023 mismatch  output  1  sticky; any checked entry failed since start.
REQ-024 mismatch_idx  output  AW  index of the first failing entry.
REQ-025 err_count, pass_count  output  16 each  saturating check counters.

Function
REQ-026 States shall be IDLE, PLAY, GAP, DRAIN, DONE.
REQ-027 IDLE->PLAY on start; a start while not in IDLE shall be ignored.
REQ-028 In PLAY, one entry shall issue per cycle: instr_out = program[idx], instr_valid = 1; otherwise instr_out = NOP_WORD and instr_valid = 0.
REQ-029 After each issue, the block shall enter GAP for exactly gap cycles when gap is nonzero, then return to PLAY.
REQ-030 count shall be latched at start; values above DEPTH shall clamp to DEPTH; count = 0 shall go IDLE->DRAIN without issuing.
REQ-031 After issuing entry count-1: with loop_mode = 1, idx shall wrap to 0; otherwise the block shall go to DRAIN.
REQ-032 A stop in PLAY or GAP shall suppress further issue and go to DRAIN; in the stop cycle, stop shall take priority over issue.
REQ-033 DRAIN shall last exactly RES_LAT cycles, then go to DONE; DONE shall pulse done for one cycle and return to IDLE.
REQ-034 A RES_LAT-deep shift pipeline shall carry {chk, expect, idx} per issued entry; NOP cycles shall insert chk = 0.
REQ-035 At the pipeline tail with chk = 1: equality shall increment pass_count; inequality shall increment err_count, set mismatch, and capture mismatch_idx only if mismatch was clear.
REQ-036 Counters shall saturate at 16'hFFFF.
REQ-037 start shall clear mismatch, mismatch_idx, err_count, pass_count and the pipeline.
REQ-038 load_en shall write only in IDLE; writes in any other state shall be ignored.
REQ-039 busy shall be 1 in PLAY, GAP, and DRAIN.

Reset
REQ-040 Reset shall force IDLE, idx = 0, instr_out = NOP_WORD, instr_valid = 0, busy = 0, done = 0, mismatch = 0, mismatch_idx = 0, both counters = 0, and the pipeline to chk = 0.
REQ-041 Program memory contents shall not be cleared by reset.
REQ-042 Reset mid-playback shall abort the run in the same cycle with no done pulse.

Structure
REQ-043 The state enum, NOP_WORD default, and counter width shall reside in the shared package riscv_tb_pkg.
REQ-044 The check pipeline shall be a sub-module, res_delay_line, parametrised by RES_LAT and payload width.

Verification
REQ-045 Load ADD 0x00c58533 (expect 35) and SUB 0x40C58533 (expect 5), count = 2, gap = 0 -> two issues on consecutive cycles, pass_count = 2, done one cycle after RES_LAT drain.
REQ-046 Same program with gap = 3 -> exactly 3 NOP_WORD cycles after each issue, with instr_valid low during them.
REQ-047 Entry 1 expect 6 against result 5 -> mismatch = 1, mismatch_idx = 1, err_count = 1.
REQ-048 loop_mode = 1, count = 3, stop after 7 issues -> issue order 0,1,2,0,1,2,0, then drain and done.
REQ-049 count = 0 -> no issue, done after RES_LAT cycles; count = DEPTH+5 -> exactly DEPTH issues.
REQ-050 Reset asserted during GAP -> next cycle IDLE, outputs at reset values, program memory intact on rerun.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
//------------------------------------------------------------------------------
// riscv_tb_pkg : shared types and constants for the instruction sequence player
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam int          CNT_W        = 16;
  localparam logic [63:0] NOP_WORD_DEF = 64'h13;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/res_delay_line.sv
//------------------------------------------------------------------------------
// res_delay_line : LAT-deep shift pipeline aligning check payloads with results
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module res_delay_line #(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_pipe [LAT];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout = r_pipe[LAT-1];

endmodule

`default_nettype wire

// File: rtl/instr_seq_player.sv
//------------------------------------------------------------------------------
// instr_seq_player : replays a stored instruction program and checks results
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_seq_player
  import riscv_tb_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 64,
  parameter int              DEPTH    = 32,
  parameter int              RES_LAT  = 1,
  parameter logic [ILEN-1:0] NOP_WORD = ILEN'(NOP_WORD_DEF),
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [ILEN-1:0]  load_instr,
  input  logic [XLEN-1:0]  load_expect,
  input  logic             load_chk,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_mode,
  input  logic [3:0]       gap,
  input  logic [AW:0]      count,
  input  logic [XLEN-1:0]  dut_result,
  output logic [ILEN-1:0]  instr_out,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [AW-1:0]    mismatch_idx,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pass_count
);

  localparam int        PW           = 1 + XLEN + AW;
  localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one      = (AW+1)'(1);
  localparam logic [2:0]  c_drain_last = 3'(RES_LAT-1);

  seq_state_t        r_state, w_next;
  logic [ILEN-1:0]   r_mem_instr [DEPTH];
  logic [XLEN-1:0]   r_mem_exp   [DEPTH];
  logic [DEPTH-1:0]  r_mem_chk;
  logic [AW-1:0]     r_idx;
  logic [AW:0]       r_count;
  logic [3:0]        r_gap_cnt;
  logic [2:0]        r_drain_cnt;
  logic              r_finish;
  logic              r_mismatch;
  logic [AW-1:0]     r_mm_idx;
  logic [CNT_W-1:0]  r_err, r_pass;

  logic              w_start, w_issue, w_last, w_more;
  logic [PW-1:0]     w_pipe_in, w_pipe_out;
  logic              w_tail_chk;
  logic [XLEN-1:0]   w_tail_exp;
  logic [AW-1:0]     w_tail_idx;

  assign w_start = (r_state == ST_IDLE) && start;
  assign w_issue = (r_state == ST_PLAY) && !stop;
  assign w_last  = ({1'b0, r_idx} == (r_count - c_one));
  assign w_more  = !w_last || loop_mode;

  // Program memory is deliberately outside the reset domain so a reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && load_en) begin
      r_mem_instr[load_addr] <= load_instr;
      r_mem_exp[load_addr]   <= load_expect;
      r_mem_chk[load_addr]   <= load_chk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_out   = NOP_WORD;
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = (count == '0) ? ST_DRAIN : ST_PLAY;
      ST_PLAY: begin
        busy = 1'b1;
        if (stop) begin
          w_next = ST_DRAIN;
        end else begin
          instr_out   = r_mem_instr[r_idx];
          instr_valid = 1'b1;
          if (gap != 4'd0) w_next = ST_GAP;
          else if (!w_more) w_next = ST_DRAIN;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (stop) w_next = ST_DRAIN;
        else if (r_gap_cnt == 4'd0) w_next = r_finish ? ST_DRAIN : ST_PLAY;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt == c_drain_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Gap and NOP cycles push chk = 0 so the tail only ever sees real issues.
  assign w_pipe_in = {w_issue & r_mem_chk[r_idx], r_mem_exp[r_idx], r_idx};
  assign {w_tail_chk, w_tail_exp, w_tail_idx} = w_pipe_out;

  res_delay_line #(
    .LAT (RES_LAT),
    .W   (PW)
  ) u_res_delay_line (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start),
    .din   (w_pipe_in),
    .dout  (w_pipe_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_count     <= '0;
      r_gap_cnt   <= '0;
      r_drain_cnt <= '0;
      r_finish    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_mm_idx    <= '0;
      r_err       <= '0;
      r_pass      <= '0;
    end else begin
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 3'd1 : 3'd0;
      if (w_start) begin
        r_idx      <= '0;
        r_count    <= (count > c_depth) ? c_depth : count;
        r_finish   <= 1'b0;
        r_mismatch <= 1'b0;
        r_mm_idx   <= '0;
        r_err      <= '0;
        r_pass     <= '0;
      end else begin
        if (w_issue) begin
          r_idx     <= w_last ? '0 : r_idx + AW'(1);
          r_gap_cnt <= gap - 4'd1;
          r_finish  <= !w_more;
        end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        if (w_tail_chk) begin
          if (dut_result == w_tail_exp) begin
            r_pass <= sat_inc(r_pass);
          end else begin
            r_err      <= sat_inc(r_err);
            r_mismatch <= 1'b1;
            if (!r_mismatch) r_mm_idx <= w_tail_idx;
          end
        end
      end
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_idx = r_mm_idx;
  assign err_count    = r_err;
  assign pass_count   = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_instr_seq_player.sv
//------------------------------------------------------------------------------
// tb_instr_seq_player : scoreboard bench for instr_seq_player
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_seq_player;
  import riscv_tb_pkg::*;

  localparam int XLEN = 64, ILEN = 64, DEPTH = 32, RES_LAT = 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [ILEN-1:0] NOP   = 64'h13;
  localparam logic [ILEN-1:0] ADD_W = 64'h00c5_8533;
  localparam logic [ILEN-1:0] SUB_W = 64'h40c5_8533;

  logic             clk = 1'b0;
  logic             reset, load_en, load_chk, start, stop, loop_mode;
  logic [AW-1:0]    load_addr;
  logic [ILEN-1:0]  load_instr;
  logic [XLEN-1:0]  load_expect;
  logic [3:0]       gap;
  logic [AW:0]      count;
  logic [XLEN-1:0]  dut_result = '0;
  logic [ILEN-1:0]  instr_out;
  logic             instr_valid, busy, done, mismatch;
  logic [AW-1:0]    mismatch_idx;
  logic [CNT_W-1:0] err_count, pass_count;

  int checks = 0, errors = 0, cyc = 0, n_issue = 0, nop_cnt = 0, done_cnt = 0;
  logic [ILEN-1:0] exp_q[$];
  int issue_cyc[$];

  instr_seq_player #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RES_LAT(RES_LAT)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_expect(load_expect), .load_chk(load_chk),
    .start(start), .stop(stop), .loop_mode(loop_mode), .gap(gap), .count(count),
    .dut_result(dut_result), .instr_out(instr_out), .instr_valid(instr_valid),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_idx(mismatch_idx),
    .err_count(err_count), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  // Reference SoC: returns a result for the instruction seen one cycle earlier.
  function automatic logic [XLEN-1:0] soc_res(input logic [ILEN-1:0] w);
    if (w == ADD_W) return 64'd35;
    if (w == SUB_W) return 64'd5;
    return {w[31:0], ~w[31:0]};
  endfunction

  function automatic logic [ILEN-1:0] gen_instr(input int i);
    return 64'h93 | (64'(i) << 20);
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    dut_result <= soc_res(instr_out);
  end

  // Scoreboard: every issued word is popped against the expected program order.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid) begin
        n_issue++;
        issue_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_issue got %h exp none", instr_out);
        end else begin
          logic [ILEN-1:0] e;
          e = exp_q.pop_front();
          if (instr_out !== e) begin errors++; $display("FAIL issue_word got %h exp %h", instr_out, e); end
        end
      end else if (busy) begin
        nop_cnt++;
        checks++;
        if (instr_out !== NOP) begin errors++; $display("FAIL nop_word got %h exp %h", instr_out, NOP); end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load(input int a, input logic [ILEN-1:0] w, input logic [XLEN-1:0] e, input logic c);
    load_en = 1'b1; load_addr = AW'(a); load_instr = w; load_expect = e; load_chk = c;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  task automatic start_run(input int cnt, input int g, input logic lp, output int s_cyc);
    n_issue = 0; nop_cnt = 0; issue_cyc.delete();
    count = (AW+1)'(cnt); gap = 4'(g); loop_mode = lp; start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int d_cyc);
    d_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin d_cyc = cyc; break; end
    end
    checks++;
    if (d_cyc < 0) begin errors++; $display("FAIL done_timeout got none exp done pulse"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_out, NOP); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mismatch !== 1'b0 || mismatch_idx !== '0) begin errors++; $display("FAIL reset_mismatch got %b/%0d exp 0/0", mismatch, mismatch_idx); end
    checks++; if (err_count !== '0 || pass_count !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", err_count, pass_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int s, d, sp;
    load(0, ADD_W, 64'd35, 1'b1);
    load(1, SUB_W, 64'd5, 1'b1);
    exp_q.push_back(ADD_W); exp_q.push_back(SUB_W);
    start_run(2, 0, 1'b0, s);
    wait_done(d);
    sp = (issue_cyc.size() >= 2) ? issue_cyc[1] - issue_cyc[0] : -1;
    checks++; if (n_issue != 2) begin errors++; $display("FAIL basic_issues got %0d exp 2", n_issue); end
    checks++; if (issue_cyc.size() < 1 || issue_cyc[0] != s + 1) begin errors++; $display("FAIL basic_first_issue got %0d exp %0d", (issue_cyc.size() > 0) ? issue_cyc[0] : -1, s + 1); end
    checks++; if (sp != 1) begin errors++; $display("FAIL basic_spacing got %0d exp 1", sp); end
    checks++; if (issue_cyc.size() < 2 || d - issue_cyc[1] != RES_LAT + 1) begin errors++; $display("FAIL basic_done_latency got %0d exp %0d", (issue_cyc.size() > 1) ? d - issue_cyc[1] : -1, RES_LAT + 1); end
    checks++; if (nop_cnt != RES_LAT) begin errors++; $display("FAIL basic_drain_cycles got %0d exp %0d", nop_cnt, RES_LAT); end
    checks++; if (pass_count !== 16'd2 || err_count !== 16'd0) begin errors++; $display("FAIL basic_counts got %0d/%0d exp 2/0", pass_count, err_count); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after_done got %b/%b exp 0/0", done, busy); end
  endtask

  task automatic test_gap;
    int s, d, sp;
    exp_q.push_back(ADD_W); exp_q.push_back(SUB_W);
    start_run(2, 3, 1'b0, s);
    wait_done(d);
    sp = (issue_cyc.size() >= 2) ? issue_cyc[1] - issue_cyc[0] : -1;
    checks++; if (sp != 4) begin errors++; $display("FAIL gap_spacing got %0d exp 4", sp); end
    checks++; if (nop_cnt != 6 + RES_LAT) begin errors++; $display("FAIL gap_nop_cycles got %0d exp %0d", nop_cnt, 6 + RES_LAT); end
    checks++; if (issue_cyc.size() < 2 || d - issue_cyc[1] != 4 + RES_LAT) begin errors++; $display("FAIL gap_done_latency got %0d exp %0d", (issue_cyc.size() > 1) ? d - issue_cyc[1] : -1, 4 + RES_LAT); end
    checks++; if (pass_count !== 16'd2) begin errors++; $display("FAIL gap_pass got %0d exp 2", pass_count); end
  endtask

  task automatic test_mismatch;
    int s, d;
    load(1, SUB_W, 64'd6, 1'b1);
    exp_q.push_back(ADD_W); exp_q.push_back(SUB_W);
    start_run(2, 0, 1'b0, s);
    wait_done(d);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag got %b exp 1", mismatch); end
    checks++; if (mismatch_idx !== AW'(1)) begin errors++; $display("FAIL mm_idx got %0d exp 1", mismatch_idx); end
    checks++; if (err_count !== 16'd1 || pass_count !== 16'd1) begin errors++; $display("FAIL mm_counts got %0d/%0d exp 1/1", err_count, pass_count); end
  endtask

  task automatic test_loop;
    int s, d;
    for (int i = 0; i < 3; i++) load(i, gen_instr(i), soc_res(gen_instr(i)), 1'b1);
    for (int k = 0; k < 7; k++) exp_q.push_back(gen_instr(k % 3));
    start_run(3, 0, 1'b1, s);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_issue >= 7) break;
    end
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(d);
    checks++; if (n_issue != 7 || exp_q.size() != 0) begin errors++; $display("FAIL loop_issues got %0d left %0d exp 7 left 0", n_issue, exp_q.size()); end
    checks++; if (nop_cnt != 1 + RES_LAT) begin errors++; $display("FAIL loop_stop_cycles got %0d exp %0d", nop_cnt, 1 + RES_LAT); end
    checks++; if (issue_cyc.size() < 7 || d - issue_cyc[6] != 2 + RES_LAT) begin errors++; $display("FAIL loop_done_latency got %0d exp %0d", (issue_cyc.size() > 6) ? d - issue_cyc[6] : -1, 2 + RES_LAT); end
    checks++; if (pass_count !== 16'd7 || err_count !== 16'd0) begin errors++; $display("FAIL loop_counts got %0d/%0d exp 7/0", pass_count, err_count); end
    exp_q.delete();
  endtask

  task automatic test_count_edges;
    int s, d;
    start_run(0, 0, 1'b0, s);
    wait_done(d);
    checks++; if (n_issue != 0) begin errors++; $display("FAIL cnt0_issues got %0d exp 0", n_issue); end
    checks++; if (d - s != RES_LAT + 1) begin errors++; $display("FAIL cnt0_done_latency got %0d exp %0d", d - s, RES_LAT + 1); end
    for (int i = 0; i < DEPTH; i++) load(i, gen_instr(i), soc_res(gen_instr(i)), 1'b1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(gen_instr(i));
    start_run(DEPTH + 5, 0, 1'b0, s);
    wait_done(d);
    checks++; if (n_issue != DEPTH || exp_q.size() != 0) begin errors++; $display("FAIL clamp_issues got %0d exp %0d", n_issue, DEPTH); end
    checks++; if (pass_count !== 16'(DEPTH) || err_count !== 16'd0) begin errors++; $display("FAIL clamp_counts got %0d/%0d exp %0d/0", pass_count, err_count, DEPTH); end
    exp_q.delete();
  endtask

  task automatic test_reset_in_gap;
    int s, d, dc0;
    load(0, ADD_W, 64'd35, 1'b1);
    load(1, SUB_W, 64'd5, 1'b1);
    exp_q.push_back(ADD_W); exp_q.push_back(SUB_W);
    start_run(2, 3, 1'b0, s);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (n_issue >= 1) break;
    end
    #1 reset = 1'b1;
    dc0 = done_cnt;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_gap_busy got %b/%b exp 0/0", busy, instr_valid); end
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL rst_gap_instr got %h exp %h", instr_out, NOP); end
    checks++; if (pass_count !== 16'd0 || mismatch !== 1'b0) begin errors++; $display("FAIL rst_gap_state got %0d/%b exp 0/0", pass_count, mismatch); end
    exp_q.delete();
    repeat (RES_LAT + 6) @(negedge clk);
    checks++; if (done_cnt != dc0 || n_issue != 1) begin errors++; $display("FAIL rst_gap_no_done got %0d/%0d exp %0d/1", done_cnt, n_issue, dc0); end
    @(posedge clk); #1;
    exp_q.push_back(ADD_W); exp_q.push_back(SUB_W);
    start_run(2, 0, 1'b0, s);
    wait_done(d);
    checks++; if (n_issue != 2 || pass_count !== 16'd2) begin errors++; $display("FAIL rst_gap_rerun got %0d/%0d exp 2/2", n_issue, pass_count); end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_instr = '0; load_expect = '0;
    load_chk = 1'b0; start = 1'b0; stop = 1'b0; loop_mode = 1'b0; gap = '0; count = '0;
    test_reset();
    test_basic();
    test_gap();
    test_mismatch();
    test_loop();
    test_count_edges();
    test_reset_in_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
